regfile_dump: RTL and testbench

- Three-port register file: two asynchronous read ports and one synchronous write port.
- Sits directly upstream of the ALU. rd1 drives ALU operand a; rd2 feeds the srcb mux into ALU operand b. The ALU result returns on wd3 via the writeback mux.
- Register 0 is hardwired to zero.
- Includes a valid/ready dump port that streams every register out for debug and bench checking, without stalling the core.

---
 rtl/regfile_dump.sv | 108 ++++++++++
 tb/tb_regfile_dump.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Three-port register file (2 async reads, 1 sync write, r0 hardwired to zero)
// with a valid/ready debug port that streams every register without stalling the core.
module regfile_dump #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [WIDTH-1:0]  wd3,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [WIDTH-1:0]  dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  regs [DEPTH];
    logic              wr_en;
    logic [ADDR_W-1:0] next_idx;
    logic [WIDTH-1:0]  next_data;

    assign wr_en = we3 && (wa3 != '0);

    // NOTE: the whole array is reset because reset must read back as all-zero;
    // a plain RAM without reset would be cheaper but would break that guarantee.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs <= '{default: '0};
        end else if (wr_en) begin
            regs[wa3] <= wd3;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        if (BYPASS != 0 && wr_en && wa3 == ra1) rd1 = wd3;
        if (BYPASS != 0 && wr_en && wa3 == ra2) rd2 = wd3;
        if (ra1 == '0) rd1 = '0;
        if (ra2 == '0) rd2 = '0;
    end

    // The beat loaded on an advancing edge must reflect a write landing on that same edge.
    always_comb begin
        next_idx  = dump_idx + ADDR_W'(1);
        next_data = regs[next_idx];
        if (wr_en && wa3 == next_idx) next_data = wd3;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            dump_valid <= 1'b0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
        end else begin
            dump_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_start) begin
                        state      <= SEND;
                        dump_valid <= 1'b1;
                        dump_busy  <= 1'b1;
                        dump_idx   <= '0;
                        dump_data  <= '0;
                    end
                end
                SEND: begin
                    if (dump_ready) begin
                        if (dump_idx == LAST_IDX) begin
                            state      <= IDLE;
                            dump_valid <= 1'b0;
                            dump_busy  <= 1'b0;
                            dump_done  <= 1'b1;
                        end else begin
                            dump_idx  <= next_idx;
                            dump_data <= next_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: directed vector table, random traffic against an
// array model, and hand-written dump sequences (stalls, mid-dump writes, reset, chaining).
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  ra1 = '0, ra2 = '0, wa3 = '0;
    logic [31:0] wd3 = '0;
    logic        we3 = 1'b0, dump_start = 1'b0, dump_ready = 1'b0;

    logic [31:0] rd1, rd2, dump_data, nb_rd1, nb_rd2, nb_dump_data;
    logic [4:0]  dump_idx, nb_dump_idx;
    logic        dump_valid, dump_busy, dump_done, nb_dump_valid, nb_dump_busy, nb_dump_done;

    int tests = 0;
    int failed = 0;

    logic [31:0] mregs    [32];
    logic [31:0] exp_dump [32];

    always #5 clk = ~clk;

    regfile_dump #(.WIDTH(32), .ADDR_W(5), .BYPASS(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we3(we3), .wa3(wa3), .wd3(wd3), .dump_start(dump_start), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_busy(dump_busy), .dump_done(dump_done)
    );

    regfile_dump #(.WIDTH(32), .ADDR_W(5), .BYPASS(0)) u_nb (
        .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2),
        .we3(we3), .wa3(wa3), .wd3(wd3), .dump_start(dump_start), .dump_valid(nb_dump_valid),
        .dump_ready(dump_ready), .dump_idx(nb_dump_idx), .dump_data(nb_dump_data),
        .dump_busy(nb_dump_busy), .dump_done(nb_dump_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference read: r0 is zero, bypass forwards a same-cycle write, otherwise stored value.
    function automatic logic [31:0] mread(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && we3 && wa3 != 0 && wa3 == a) return wd3;
        return mregs[a];
    endfunction

    // Advance one clock, applying the write the model sees on that edge; leaves time at edge+1.
    task automatic tick();
        @(posedge clk);
        if (we3 && wa3 != 0) mregs[wa3] = wd3;
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] e1_nb;
    } vec_t;

    // Runs one dump from the bench's own beat count; optional start pulse, ready toggling,
    // mid-dump writes, and a new start asserted during the dump_done cycle.
    task automatic run_dump(input bit do_start, input bit toggle, input bit writes, input bit chain);
        int hs = 0;
        int c = 0;
        bit held = 0;
        logic [4:0]  pidx = '0;
        logic [31:0] pdata = '0;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        if (do_start) begin
            dump_start = 1'b1;
            tick();
            dump_start = 1'b0;
        end
        while (hs < 32 && c < 300) begin
            dump_ready = toggle ? pat[c % 4] : 1'b1;
            dump_start = toggle && hs >= 3 && hs < 6;
            we3 = 1'b0;
            if (writes && hs == 6) begin we3 = 1'b1; wa3 = 5'd7; wd3 = 32'hCAFEF00D; end
            if (writes && hs == 2) begin we3 = 1'b1; wa3 = 5'd2; wd3 = 32'h0000AAAA; end
            @(negedge clk);
            check("dump_valid", {31'b0, dump_valid}, 32'd1);
            check("dump_busy", {31'b0, dump_busy}, 32'd1);
            if (held) begin
                check("hold_idx", {27'b0, dump_idx}, {27'b0, pidx});
                check("hold_data", dump_data, pdata);
            end
            if (dump_ready) begin
                check("beat_idx", {27'b0, dump_idx}, hs);
                check("beat_data", dump_data, exp_dump[hs]);
                hs++;
            end
            held  = !dump_ready;
            pidx  = dump_idx;
            pdata = dump_data;
            c++;
            tick();
        end
        we3 = 1'b0;
        dump_ready = 1'b0;
        if (hs != 32) check("dump_handshakes", hs, 32);
        dump_start = chain;
        @(negedge clk);
        check("done_pulse", {31'b0, dump_done}, 32'd1);
        check("done_busy", {31'b0, dump_busy}, 32'd0);
        check("done_valid", {31'b0, dump_valid}, 32'd0);
        tick();
        dump_start = 1'b0;
        @(negedge clk);
        check("done_drop", {31'b0, dump_done}, 32'd0);
        check("after_busy", {31'b0, dump_busy}, {31'b0, chain});
        if (chain) check("restart_idx", {27'b0, dump_idx}, 32'd0);
        tick();
    endtask

    initial begin
        vec_t vecs [8];
        vecs[0] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd31, 32'h0,        32'h0,        32'h0};
        vecs[1] = '{1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0,  32'h0,        32'h0,        32'h0};
        vecs[2] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0,  32'h0,        32'h0,        32'h0};
        vecs[3] = '{1'b1, 5'd5, 32'h12345678, 5'd5, 5'd5,  32'h12345678, 32'h12345678, 32'h0};
        vecs[4] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0,  32'h12345678, 32'h0,        32'h12345678};
        vecs[5] = '{1'b1, 5'd5, 32'h1,        5'd5, 5'd6,  32'h1,        32'h0,        32'h12345678};
        vecs[6] = '{1'b1, 5'd6, 32'h2,        5'd5, 5'd6,  32'h1,        32'h2,        32'h1};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        5'd6, 5'd5,  32'h2,        32'h1,        32'h2};

        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        #12 reset_n = 1'b1;
        tick();

        @(negedge clk);
        check("rst_valid", {31'b0, dump_valid}, 32'd0);
        check("rst_busy", {31'b0, dump_busy}, 32'd0);
        check("rst_done", {31'b0, dump_done}, 32'd0);
        check("rst_idx", {27'b0, dump_idx}, 32'd0);
        check("rst_data", dump_data, 32'd0);
        tick();

        for (int i = 0; i < 8; i++) begin
            we3 = vecs[i].we; wa3 = vecs[i].wa; wd3 = vecs[i].wd;
            ra1 = vecs[i].a1; ra2 = vecs[i].a2;
            @(negedge clk);
            check($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
            check($sformatf("vec%0d_nb_rd1", i), nb_rd1, vecs[i].e1_nb);
            tick();
        end

        for (int i = 0; i < 200; i++) begin
            we3 = 1'($urandom_range(0, 1));
            wa3 = 5'($urandom_range(0, 31));
            wd3 = $urandom;
            ra1 = ($urandom_range(0, 3) == 0) ? wa3 : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? wa3 : 5'($urandom_range(0, 31));
            @(negedge clk);
            check("rand_rd1", rd1, mread(ra1, 1'b1));
            check("rand_rd2", rd2, mread(ra2, 1'b1));
            check("rand_nb_rd1", nb_rd1, mread(ra1, 1'b0));
            check("rand_nb_rd2", nb_rd2, mread(ra2, 1'b0));
            tick();
        end

        for (int i = 1; i < 32; i++) begin
            we3 = 1'b1; wa3 = 5'(i); wd3 = i * 32'h11;
            tick();
        end
        we3 = 1'b0;
        for (int i = 0; i < 32; i++) exp_dump[i] = i * 32'h11;

        run_dump(1'b1, 1'b0, 1'b0, 1'b1);
        run_dump(1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 32; i++) exp_dump[i] = mregs[i];
        exp_dump[7] = 32'hCAFEF00D;
        run_dump(1'b1, 1'b0, 1'b1, 1'b0);
        ra1 = 5'd2;
        @(negedge clk);
        check("late_write_r2", rd1, 32'h0000AAAA);
        tick();

        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        dump_ready = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check("abort_idx", {27'b0, dump_idx}, 32'd10);
        #2 reset_n = 1'b0;
        #1;
        check("abort_valid", {31'b0, dump_valid}, 32'd0);
        check("abort_busy", {31'b0, dump_busy}, 32'd0);
        check("abort_data", dump_data, 32'd0);
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            #1;
            check("abort_rd1", rd1, 32'h0);
            check("abort_rd2", rd2, 32'h0);
        end
        dump_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) exp_dump[i] = 32'h0;
        run_dump(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
